// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store/AMO sequencer in front of a byte-addressed RAM.
// Optional AMO path is built only when MEM_ACCESS_AMO_EN is defined; otherwise op 10 is rejected as misaligned.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [2:0]  req_amo_fn,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_exc,
    output logic        mem_enable,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_data,
    output logic [1:0]  mem_memo,
    output logic [7:0]  mem_mask,
    input  logic [63:0] mem_resp,
    input  logic [1:0]  mem_exc
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready high
    // ACC    | RAM read (load/AMO) or write (store) cycle
    // AMO_WR | write-back of the AMO result
    // RESP   | response held until rsp_ready
`ifdef MEM_ACCESS_AMO_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, AMO_WR = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd3} state_t;
`endif

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_AMO   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_data_q;
    logic [1:0]  rsp_exc_q;
    logic        misalign;
    logic [7:0]  mask_w;

    function automatic logic [63:0] trunc(input logic [63:0] v, input logic [1:0] sz);
        case (sz)
            2'b00:   trunc = {56'd0, v[7:0]};
            2'b01:   trunc = {48'd0, v[15:0]};
            2'b10:   trunc = {32'd0, v[31:0]};
            default: trunc = v;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz, input logic uns);
        case (sz)
            2'b00:   extend = uns ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
            2'b01:   extend = uns ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            2'b10:   extend = uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default: extend = v;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Reserved ops, and AMO when not built, share the misaligned exception path.
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            2'b11:   misalign = |req_addr[2:0];
            default: misalign = 1'b0;
        endcase
        if (req_op == OP_RSVD) misalign = 1'b1;
`ifndef MEM_ACCESS_AMO_EN
        if (req_op == OP_AMO) misalign = 1'b1;
`endif
    end

    assign mask_w = size_mask(size_q);

`ifdef MEM_ACCESS_AMO_EN
    logic [2:0]  fn_q;
    logic [63:0] new_q;
    logic [63:0] old_w;
    logic [63:0] amo_raw;
    logic [63:0] new_d;

    always_comb begin
        old_w = trunc(mem_resp, size_q);
        case (fn_q)
            3'b001:  amo_raw = old_w + data_q;
            3'b010:  amo_raw = old_w & data_q;
            3'b011:  amo_raw = old_w | data_q;
            3'b100:  amo_raw = old_w ^ data_q;
            default: amo_raw = data_q;
        endcase
        new_d = trunc(amo_raw, size_q);
    end
`else
    logic unused_amo_fn;
    assign unused_amo_fn = ^req_amo_fn;
`endif

    // RAM port is decoded from the state so reset silences it without waiting for a clock.
    always_comb begin
        mem_enable = 1'b0;
        mem_memo   = 2'b00;
        mem_mask   = 8'h00;
        mem_addr   = addr_q;
        mem_data   = data_q;
        if (state_q == ACC) begin
            mem_enable = (mem_exc == 2'b00);
            mem_memo   = (op_q == OP_STORE) ? 2'b01 : 2'b00;
            mem_mask   = mask_w;
        end
`ifdef MEM_ACCESS_AMO_EN
        if (state_q == AMO_WR) begin
            mem_enable = (mem_exc == 2'b00);
            mem_memo   = 2'b01;
            mem_mask   = mask_w;
            mem_data   = new_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_exc_q   <= 2'b00;
`ifdef MEM_ACCESS_AMO_EN
            fn_q        <= 3'b000;
            new_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        addr_q <= req_addr;
                        data_q <= req_data;
`ifdef MEM_ACCESS_AMO_EN
                        fn_q   <= req_amo_fn;
`endif
                        if (misalign) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_exc_q   <= 2'b01;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_exc_q   <= 2'b00;
                    rsp_data_q  <= '0;
                    if (mem_exc != 2'b00) begin
                        rsp_exc_q <= mem_exc;
                    end else if (op_q == OP_LOAD) begin
                        rsp_data_q <= extend(mem_resp, size_q, uns_q);
                    end
`ifdef MEM_ACCESS_AMO_EN
                    else if (op_q == OP_AMO) begin
                        rsp_data_q  <= extend(mem_resp, size_q, 1'b0);
                        new_q       <= new_d;
                        rsp_valid_q <= 1'b0;
                        state_q     <= AMO_WR;
                    end
`endif
                end
`ifdef MEM_ACCESS_AMO_EN
                AMO_WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    if (mem_exc != 2'b00) rsp_exc_q <= mem_exc;
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_exc   = rsp_exc_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
Parameters: none.
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port req_valid  input  1  core request present.
REQ-004 SHALL have port req_ready  output  1  unit can accept a request.
REQ-005 SHALL have port req_op  input  2  00 load, 01 store, 10 AMO, 11 reserved.
REQ-006 SHALL have port req_size  input  2  log2 bytes: 00 B, 01 H, 10 W, 11 D.
REQ-007 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-008 SHALL have port req_amo_fn  input  3  000 SWAP, 001 ADD, 010 AND, 011 OR, 100 XOR.
REQ-009 SHALL have ports req_addr and req_data  input  64 each  byte address and store/AMO operand, low-justified.
REQ-010 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, 64), rsp_exc (output, 2)  response handshake, load/AMO old value, exception code (00 none, 01 misaligned, 10 access fault).
REQ-011 SHALL have ports mem_enable, mem_addr[63:0], mem_data[63:0], mem_memo[1:0], mem_mask[7:0] (outputs) and mem_resp[63:0], mem_exc[1:0] (inputs)  data port of the downstream byte-addressed RAM; mem_memo 00 read, 01 write.

Function
REQ-012 SHALL implement FSM states IDLE, ACC, AMO_WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-013 SHALL register op, size, unsigned, amo_fn, addr and data on req_valid && req_ready.
REQ-014 SHALL flag misaligned when addr is not size-aligned (H: addr[0]; W: addr[1:0]; D: addr[2:0] non-zero); op 11 SHALL be treated as misaligned.
REQ-015 On a misaligned accept, SHALL go IDLE->RESP with rsp_exc=01, rsp_data=0, and never assert mem_enable for that request.
REQ-016 Otherwise SHALL go IDLE->ACC; mem_addr = registered addr; mem_mask = (1<<2^size)-1 (B 0x01, H 0x03, W 0x0F, D 0xFF).
REQ-017 In ACC, mem_memo SHALL be 01 for store and 00 for load/AMO; mem_data SHALL be the registered data.
REQ-018 mem_enable SHALL be 1 only in ACC and AMO_WR and only when mem_exc==00 (combinational gate).
REQ-019 In ACC with mem_exc!=00, SHALL go to RESP with rsp_exc=mem_exc, rsp_data=0, no write.
REQ-020 Load in ACC SHALL capture mem_resp truncated to size and sign/zero-extended to 64 bits into rsp_data; store SHALL set rsp_data=0; both go to RESP.
REQ-021 AMO in ACC SHALL capture the extended old value into rsp_data, compute new = fn(old, data) truncated to size, and go to AMO_WR.
REQ-022 In AMO_WR, SHALL drive mem_memo=01, mem_data=new, same addr/mask, then go to RESP.
REQ-023 In RESP, rsp_valid SHALL be 1 with rsp_data/rsp_exc stable; on rsp_ready SHALL return to IDLE; no new request accepted in the handshake cycle.
REQ-024 Latency accept->rsp_valid SHALL be 2 cycles load/store, 3 cycles AMO, 1 cycle misaligned.
REQ-025 ADD SHALL wrap modulo 2^(8*bytes); W ADD of 0x7FFFFFFF+1 SHALL store 0x80000000 and return old value sign-extended.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, rsp_valid=0, rsp_data=0, rsp_exc=00, mem_enable=0, mem_memo=00, mem_mask=0; an in-flight request SHALL be dropped with no write.
REQ-027 After reset deasserts, req_ready SHALL be 1.

Configuration
REQ-028 Macro MEM_ACCESS_AMO_EN: when defined, AMO (op 10) and AMO_WR SHALL operate per REQ-021/022.
REQ-029 When MEM_ACCESS_AMO_EN is undefined, AMO_WR and AMO datapath SHALL be absent and op 10 SHALL be treated as misaligned (rsp_exc=01).

Verification
REQ-030 Load B, unsigned=0, addr 0x100, mem byte 0x80 -> rsp_data 0xFFFFFFFFFFFFFF80, rsp_exc 00, rsp_valid 2 cycles after accept.
REQ-031 Store W, addr 0x204, data 0x11223344 -> one mem_enable cycle, mem_memo 01, mem_mask 0x0F; subsequent load W unsigned returns 0x11223344.
REQ-032 Load H at addr 0x101 -> rsp_exc 01 after 1 cycle, mem_enable never asserted.
REQ-033 Load D at addr 0x0000000100000000 with mem_exc=10 -> rsp_exc 10, rsp_data 0, no write.
REQ-034 With MEM_ACCESS_AMO_EN: AMO ADD W at 0x300 holding 0x7FFFFFFF, data 1 -> rsp_data 0x7FFFFFFF after 3 cycles; memory holds 0x80000000.
REQ-035 Reset asserted during ACC of a store -> outputs reset immediately, target memory bytes unchanged, req_ready 1 after release.
